// File: rtl/icache_pkg.sv
// ============================================================================
// Module      : icache_pkg
// Description : Shared types and constants for the direct-mapped I-cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } icache_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_array.sv
// ============================================================================
// Module      : icache_array
// Description : Tag/data/valid storage, synchronous write, combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 7,
    parameter int TAG_W      = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_all,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_hit,
    output logic [INST_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [INST_W-1:0]     wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [INST_W-1:0] r_data [LINES];

    // Only the valid bits are reset; tag/data contents are don't-care until valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (clear_all) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[wr_index]  <= wr_tag;
            r_data[wr_index] <= wr_data;
        end
    end

    assign rd_hit  = r_valid[rd_index] && (r_tag[rd_index] == rd_tag);
    assign rd_data = r_data[rd_index];

endmodule

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
// Module      : icache
// Description : Direct-mapped read-only instruction cache, one word per line.
//               Optional ICACHE_FLUSH_EN adds fence_i (clear all lines + flush).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int INDEX_BITS = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              flush,
`ifdef ICACHE_FLUSH_EN
    input  logic              fence_i,
`endif
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_fe,
    output logic [ADDR_W-1:0] inst_fpc,
    input  logic [INST_W-1:0] inst_i,
    input  logic              inst_ok_i,
    input  logic [ADDR_W-1:0] inst_pc_i
);

    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    icache_state_t     r_state;
    logic [ADDR_W-1:0] r_miss_pc;

    logic              w_hit;
    logic [INST_W-1:0] w_rd_data;
    logic              w_cancel;
    logic              w_clear_all;
    logic              w_retarget;
    logic              w_miss_done;

`ifdef ICACHE_FLUSH_EN
    assign w_clear_all = fence_i;
    assign w_cancel    = flush | fence_i;
`else
    assign w_clear_all = 1'b0;
    assign w_cancel    = flush;
`endif

    assign w_retarget  = if_req && (if_pc != r_miss_pc);
    assign w_miss_done = inst_ok_i && (inst_pc_i == r_miss_pc);

    // Every returning word is written, even stale or cancelled ones: it is correct for its pc.
    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .clear_all (w_clear_all),
        .rd_index  (if_pc[INDEX_BITS+1:2]),
        .rd_tag    (if_pc[ADDR_W-1:INDEX_BITS+2]),
        .rd_hit    (w_hit),
        .rd_data   (w_rd_data),
        .wr_en     (inst_ok_i),
        .wr_index  (inst_pc_i[INDEX_BITS+1:2]),
        .wr_tag    (inst_pc_i[ADDR_W-1:INDEX_BITS+2]),
        .wr_data   (inst_i)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_miss_pc  <= '0;
            inst_o     <= ZERO_WORD;
            inst_valid <= 1'b0;
            inst_pc_o  <= '0;
            inst_fe    <= 1'b0;
            inst_fpc   <= '0;
        end else begin
            inst_valid <= 1'b0;
            if (w_cancel) begin
                r_state <= ST_IDLE;
                inst_fe <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (if_req && w_hit) begin
                            inst_valid <= 1'b1;
                            inst_o     <= w_rd_data;
                            inst_pc_o  <= if_pc;
                        end else if (if_req) begin
                            r_state   <= ST_MISS;
                            r_miss_pc <= if_pc;
                            inst_fe   <= 1'b1;
                            inst_fpc  <= if_pc;
                        end
                    end
                    ST_MISS: begin
                        // A retarget outranks completion of the old miss.
                        if (w_retarget && w_hit) begin
                            inst_valid <= 1'b1;
                            inst_o     <= w_rd_data;
                            inst_pc_o  <= if_pc;
                            inst_fe    <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else if (w_retarget) begin
                            r_miss_pc <= if_pc;
                            inst_fpc  <= if_pc;
                        end else if (w_miss_done) begin
                            inst_valid <= 1'b1;
                            inst_o     <= inst_i;
                            inst_pc_o  <= r_miss_pc;
                            inst_fe    <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        inst_fe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
